qos_egress_wrr: RTL and testbench
=================================

Name: qos_egress_wrr

Overview:
- Downstream stage of the QoS/PCIe switch core; consumes the four egress FIFOs (P0..P3).
- Drains them by weighted round-robin into a single 12-bit output stream with a valid/ready handshake.
- Issues one-cycle pop pulses toward the egress FIFOs and tags each output word with its source port.

Parameters:
- DW, 12, data word width (matches FIFO word).
- W0, 4, WRR weight of port 0 (words per turn); 0 treated as 1.
- W1, 3, weight of port 1; 0 treated as 1.
- W2, 2, weight of port 2; 0 treated as 1.
- W3, 1, weight of port 3; 0 treated as 1.
- CW, 4, credit counter width; weights must be < 2^CW.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fifo_data0..fifo_data3  in  DW each  egress FIFO read data (valid the cycle after pop)
- fifo_empty0..fifo_empty3  in  1 each  egress FIFO empty flags
- pop0..pop3  out  1 each  FIFO read pulses, at most one high per cycle
- data_out  out  DW  registered output word
- port_out  out  2  source port of data_out
- valid_out  out  1  data_out/port_out valid
- ready_in  in  1  downstream accepts word when valid_out&&ready_in

Behaviour:
- Reset (async, active-high): state=ARB, ptr=0, cred=W0 (eff.), pop0..3=0, data_out=0, port_out=0, valid_out=0.
- States: ARB, CAP, SEND. All outputs registered.
- ARB: if all empties high -> stay ARB, no pop. Else pick sel: ptr if !empty[ptr] && cred!=0; otherwise first non-empty port in order ptr+1, ptr+2, ptr+3, ptr (mod 4); on switch, ptr=sel, cred=Wsel (eff.). Assert pop[sel] for exactly one cycle; go CAP.
- CAP: latch fifo_data[sel] into data_out, port_out=sel, valid_out=1; go SEND.
- SEND: hold data_out/port_out/valid_out stable while ready_in=0. On ready_in=1: valid_out=0, cred=cred-1, go ARB.
- cred reaching 0 forces move to next non-empty port at next ARB; if it is the only non-empty port, it is reselected with cred reloaded.
- Latency: pop at cycle t, valid_out high at t+2; minimum 3 cycles per word (ARB, CAP, SEND with ready_in=1).
- Never pop an empty FIFO: empties sampled in ARB the same cycle pop is driven.
- ptr wraps 3->0; cred never underflows (decrement only after a selected transfer, cred>=1).
- ready_in high while valid_out low: ignored.
- Reset mid-operation: in-flight popped word discarded; no pop or valid glitch after release.

Optional Feature:
- Macro EGRESS_STATS_EN.
- Defined: adds ports stat_sel (in, 2), stat_clr (in, 1), and stat_cnt (out, 16).
  - Four 16-bit saturating counters, one per port, increment on each accepted transfer (valid_out&&ready_in) for port_out.
  - stat_cnt is a combinational read of counter[stat_sel].
  - stat_clr zeros all counters synchronously; clear wins over increment in the same cycle.
  - Reset clears all counters.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset with all empties=1, ready_in=1 for 20 cycles -> pop0..3=0, valid_out=0, data_out=0 throughout.
- Port 2 only non-empty, fifo_data2=12'hA5C, ready_in=1 -> pop2 pulse, valid_out two cycles later with data_out=12'hA5C, port_out=2, repeated every 3 cycles.
- All four non-empty, ready_in=1, default weights -> grant sequence per 10 words: 0,0,0,0,1,1,1,2,2,3, then repeats.
- Word from port 1 (12'h123) pending, ready_in=0 for 5 cycles -> data_out=12'h123, port_out=1, valid_out=1 stable, no pop during stall; one transfer when ready_in rises.
- Port 0 goes empty after 2 of 4 credits while ports 1,3 non-empty -> next grant port 1 with cred=3; port 0 regains full W0 on its next turn.
- Assert reset in CAP state -> valid_out stays 0, ptr=0, next grant after release starts from port 0; with EGRESS_STATS_EN, 3 accepted port-3 words -> stat_sel=3 gives stat_cnt=3; stat_clr gives 0.

Source files
------------

// File: rtl/qos_egress_wrr.sv
// Weighted round-robin drain of the four egress FIFOs into one tagged DW-bit valid/ready stream.
// Optional per-port transfer counters are compiled in when EGRESS_STATS_EN is defined.
module qos_egress_wrr #(
    parameter int DW = 12,
    parameter int W0 = 4,
    parameter int W1 = 3,
    parameter int W2 = 2,
    parameter int W3 = 1,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] fifo_data0,
    input  logic [DW-1:0] fifo_data1,
    input  logic [DW-1:0] fifo_data2,
    input  logic [DW-1:0] fifo_data3,
    input  logic          fifo_empty0,
    input  logic          fifo_empty1,
    input  logic          fifo_empty2,
    input  logic          fifo_empty3,
    output logic          pop0,
    output logic          pop1,
    output logic          pop2,
    output logic          pop3,
    output logic [DW-1:0] data_out,
    output logic [1:0]    port_out,
    output logic          valid_out,
    input  logic          ready_in
`ifdef EGRESS_STATS_EN
    ,
    input  logic [1:0]    stat_sel,
    input  logic          stat_clr,
    output logic [15:0]   stat_cnt
`endif
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        CAP  = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic logic [CW-1:0] eff_weight(input int w);
        return (w == 0) ? CW'(1) : CW'(w);
    endfunction

    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    logic [DW-1:0] fifo_data [4];
    logic [CW-1:0] weight    [4];
    logic [3:0]    non_empty;

    assign fifo_data[0] = fifo_data0;
    assign fifo_data[1] = fifo_data1;
    assign fifo_data[2] = fifo_data2;
    assign fifo_data[3] = fifo_data3;
    assign weight[0]    = eff_weight(W0);
    assign weight[1]    = eff_weight(W1);
    assign weight[2]    = eff_weight(W2);
    assign weight[3]    = eff_weight(W3);
    assign non_empty    = ~{fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cred_q, cred_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [1:0]    port_out_q, port_out_d;
    logic          valid_out_q, valid_out_d;
    logic [3:0]    pop_vec;
    logic [1:0]    pick;
    logic [1:0]    cand;
    logic          found;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cred_d      = cred_q;
        data_out_d  = data_out_q;
        port_out_d  = port_out_q;
        valid_out_d = valid_out_q;
        pop_vec     = 4'b0000;
        pick        = ptr_q;
        cand        = ptr_q;
        found       = 1'b0;
        unique case (state_q)
            ARB: begin
                if (|non_empty) begin
                    if (!(non_empty[ptr_q] && cred_q != '0)) begin
                        // Search ptr+1, ptr+2, ptr+3 and finally ptr itself.
                        for (int k = 1; k <= 4; k++) begin
                            cand = ptr_q + 2'(k);
                            if (!found && non_empty[cand]) begin
                                pick  = cand;
                                found = 1'b1;
                            end
                        end
                        ptr_d  = pick;
                        cred_d = weight[pick];
                    end
                    pop_vec[pick] = 1'b1;
                    sel_d         = pick;
                    state_d       = CAP;
                end
            end
            CAP: begin
                data_out_d  = fifo_data[sel_q];
                port_out_d  = sel_q;
                valid_out_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (ready_in) begin
                    valid_out_d = 1'b0;
                    if (cred_q != '0) begin
                        cred_d = cred_q - CRED_ONE;
                    end
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            ptr_q       <= 2'd0;
            sel_q       <= 2'd0;
            cred_q      <= eff_weight(W0);
            data_out_q  <= '0;
            port_out_q  <= 2'd0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cred_q      <= cred_d;
            data_out_q  <= data_out_d;
            port_out_q  <= port_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Pop is decoded from registered state during ARB so the FIFO read data lands in CAP.
    assign pop0      = pop_vec[0] & ~reset;
    assign pop1      = pop_vec[1] & ~reset;
    assign pop2      = pop_vec[2] & ~reset;
    assign pop3      = pop_vec[3] & ~reset;
    assign data_out  = data_out_q;
    assign port_out  = port_out_q;
    assign valid_out = valid_out_q;

`ifdef EGRESS_STATS_EN
    logic [15:0] stat_view [4];
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_stat
        logic [15:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (stat_clr) begin
                cnt_d = '0;
            end else if (valid_out_q && ready_in && port_out_q == 2'(gi) && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
        assign stat_view[gi] = cnt_q;
    end
    assign stat_cnt = stat_view[stat_sel];
`endif

endmodule

// File: tb/tb_qos_egress_wrr.sv
// Directed bench for qos_egress_wrr: FIFO model, grant/acceptance log and immediate-assertion checks.
// Covers the EGRESS_STATS_EN counters when that macro is defined.
module tb_qos_egress_wrr;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready_in;
    logic [DW-1:0] d [4];
    int            avail [4];
    int            popped [4] = '{default: 0};
    logic [3:0]    fe;
    logic          pop0, pop1, pop2, pop3;
    logic [3:0]    pops;
    logic [DW-1:0] data_out;
    logic [1:0]    port_out;
    logic          valid_out;
`ifdef EGRESS_STATS_EN
    logic [1:0]    stat_sel;
    logic          stat_clr;
    logic [15:0]   stat_cnt;
`endif

    logic [1:0]    acc_port [1024];
    logic [DW-1:0] acc_data [1024];
    int            acnt = 0;
    int            viol = 0;
    int            passed = 0;
    int            fails = 0;
    int            total = 0;
    int            base;
    int            wrr_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int            t5_seq  [11] = '{0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    assign fe[0] = (popped[0] >= avail[0]);
    assign fe[1] = (popped[1] >= avail[1]);
    assign fe[2] = (popped[2] >= avail[2]);
    assign fe[3] = (popped[3] >= avail[3]);
    assign pops  = {pop3, pop2, pop1, pop0};

    qos_egress_wrr dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_data0 (d[0]),
        .fifo_data1 (d[1]),
        .fifo_data2 (d[2]),
        .fifo_data3 (d[3]),
        .fifo_empty0(fe[0]),
        .fifo_empty1(fe[1]),
        .fifo_empty2(fe[2]),
        .fifo_empty3(fe[3]),
        .pop0       (pop0),
        .pop1       (pop1),
        .pop2       (pop2),
        .pop3       (pop3),
        .data_out   (data_out),
        .port_out   (port_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
`ifdef EGRESS_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt)
`endif
    );

    // FIFO model: a pop seen at the clock edge consumes one word; accepted words are logged.
    always @(posedge clk) begin
        if (reset) begin
            if (pops != 4'b0000) viol <= viol + 1;
        end else begin
            if ($countones(pops) > 1) viol <= viol + 1;
            for (int p = 0; p < 4; p++) begin
                if (pops[p]) begin
                    if (popped[p] >= avail[p]) viol <= viol + 1;
                    popped[p] <= popped[p] + 1;
                end
            end
            if (valid_out && ready_in) begin
                acc_port[acnt] <= port_out;
                acc_data[acnt] <= data_out;
                acnt           <= acnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (acnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, acnt, target);
    endtask

    task automatic drain_all();
        for (int p = 0; p < 4; p++) avail[p] = popped[p];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            avail[p] = 0;
            d[p]     = '0;
        end
        ready_in = 1'b1;
`ifdef EGRESS_STATS_EN
        stat_sel = 2'd0;
        stat_clr = 1'b0;
`endif
        // Reset and idle with every FIFO empty.
        @(negedge clk);
        @(negedge clk);
        chk("rst_pop", pops, 4'b0000);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_data", data_out, 12'h000);
        chk("rst_port", port_out, 2'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_pop", pops, 4'b0000);
            chk("idle_valid", valid_out, 1'b0);
            chk("idle_data", data_out, 12'h000);
        end

        // Port 2 alone: pop every third cycle, word valid two cycles after its pop.
        d[2]     = 12'hA5C;
        avail[2] = popped[2] + 100;
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            chk("p2_pop", pops, (i % 3 == 0) ? 4'b0100 : 4'b0000);
            chk("p2_valid", valid_out, (i % 3 == 2) ? 1'b1 : 1'b0);
            if (i % 3 == 2) begin
                chk("p2_data", data_out, 12'hA5C);
                chk("p2_port", port_out, 2'd2);
            end
        end
        drain_all();
        repeat (3) @(negedge clk);
        chk("p2_stop_pop", pops, 4'b0000);

        // All four ports busy: two rounds of the default-weight grant pattern.
        do_reset();
        d[0] = 12'h0F0;
        d[1] = 12'h1E1;
        d[2] = 12'h2D2;
        d[3] = 12'h3C3;
        for (int p = 0; p < 4; p++) avail[p] = popped[p] + 100;
        base = acnt;
        wait_acc(base + 20, 200, "wrr_count");
        drain_all();
        for (int k = 0; k < 20; k++) begin
            chk("wrr_port", acc_port[base + k], wrr_seq[k % 10]);
            chk("wrr_data", acc_data[base + k], d[wrr_seq[k % 10]]);
        end
        repeat (4) @(negedge clk);

        // Back-pressure: a port-1 word holds steady for five stalled cycles.
        do_reset();
        d[1]     = 12'h123;
        avail[1] = popped[1] + 1;
        ready_in = 1'b0;
        base     = acnt;
        #1;
        chk("stall_first_pop", pops, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", valid_out, 1'b1);
            chk("stall_data", data_out, 12'h123);
            chk("stall_port", port_out, 2'd1);
            chk("stall_pop", pops, 4'b0000);
            @(negedge clk);
        end
        chk("stall_no_xfer", acnt, base);
        ready_in = 1'b1;
        @(negedge clk);
        chk("stall_valid_drop", valid_out, 1'b0);
        chk("stall_one_xfer", acnt, base + 1);
        chk("stall_acc_data", acc_data[base], 12'h123);
        repeat (3) @(negedge clk);
        chk("stall_single", acnt, base + 1);

        // Port 0 runs dry after two words, then refills and regains its full weight.
        do_reset();
        avail[0] = popped[0] + 2;
        avail[1] = popped[1] + 10;
        avail[2] = popped[2];
        avail[3] = popped[3] + 10;
        base     = acnt;
        wait_acc(base + 5, 60, "dry_count5");
        avail[0] = popped[0] + 10;
        wait_acc(base + 11, 80, "dry_count11");
        drain_all();
        for (int k = 0; k < 11; k++) begin
            chk("dry_port", acc_port[base + k], t5_seq[k]);
        end
        repeat (4) @(negedge clk);

        // Reset asserted while a port-3 word sits in CAP.
        do_reset();
        avail[3] = popped[3] + 5;
        #1;
        chk("cap_first_pop", pops, 4'b1000);
        @(negedge clk);
        chk("cap_valid", valid_out, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_pop", pops, 4'b0000);
        avail[0] = popped[0] + 5;
        @(negedge clk);
        chk("midrst_valid2", valid_out, 1'b0);
        chk("midrst_data", data_out, 12'h000);
        reset = 1'b0;
        #1;
        chk("postrst_pop", pops, 4'b0001);
        @(negedge clk);
        chk("postrst_cap_valid", valid_out, 1'b0);
        @(negedge clk);
        chk("postrst_valid", valid_out, 1'b1);
        chk("postrst_port", port_out, 2'd0);
        chk("postrst_data", data_out, 12'h0F0);
        drain_all();
        repeat (4) @(negedge clk);
        chk("postrst_quiet", pops, 4'b0000);

`ifdef EGRESS_STATS_EN
        // Per-port transfer counters.
        do_reset();
        stat_sel = 2'd3;
        #1;
        chk("stat_rst", stat_cnt, 16'd0);
        avail[3] = popped[3] + 3;
        base     = acnt;
        wait_acc(base + 3, 40, "stat_xfers");
        repeat (2) @(negedge clk);
        chk("stat_p3", stat_cnt, 16'd3);
        stat_sel = 2'd0;
        #1;
        chk("stat_p0", stat_cnt, 16'd0);
        stat_sel = 2'd3;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("stat_clr", stat_cnt, 16'd0);
`endif

        chk("pop_rules", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
